// File: rtl/sa_ctrl_nxn.sv
`default_nettype none
// ============================================================================
// Module      : sa_ctrl_nxn
// Description : Control unit for an NxN output-stationary systolic array of
//               MAC PEs. Generates operand-buffer write addresses for a
//               2*N*N byte host load (N*N weights, then N*N inputs).
//               It sequences skewed operand selects into the array edge and
//               pulses clear at compute start. It then snapshots the N*N
//               accumulators and streams them to the host one byte at a
//               time over a valid/ready handshake.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               i_load_en        - host operand byte strobe
//               i_c_flat         - accumulators, PE(i,j) at [(i*N+j)*AW +: AW]
//               i_out_ready      - host accepts o_out_byte
//               o_mem_addr/o_mem_we - operand buffer write port
//               o_clear, o_pe_en - array clear pulse / advance enable
//               o_a_sel, o_b_sel - per-slot operand selects (code N = zero)
//               o_out_byte/o_out_valid - result byte stream
//               o_busy, o_done, o_load_err - status
// Revision    : 1.0 - initial release
// ============================================================================
module sa_ctrl_nxn #(
    parameter int N    = 2,
    parameter int AW   = 16,
    parameter int SELW = $clog2(N + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_load_en,
    input  logic [N*N*AW-1:0]          i_c_flat,
    input  logic                       i_out_ready,
    output logic [$clog2(2*N*N)-1:0]   o_mem_addr,
    output logic                       o_mem_we,
    output logic                       o_clear,
    output logic                       o_pe_en,
    output logic [N*SELW-1:0]          o_a_sel,
    output logic [N*SELW-1:0]          o_b_sel,
    output logic [7:0]                 o_out_byte,
    output logic                       o_out_valid,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_load_err
);

    localparam int c_MAW    = $clog2(2 * N * N);
    localparam int c_BPP    = AW / 8;            // bytes per accumulator
    localparam int c_NBYTES = N * N * c_BPP;     // bytes in one result stream
    localparam int c_BW     = $clog2(c_NBYTES);
    localparam int c_KW     = $clog2(3 * N);     // holds 0 .. 3N-2

    localparam logic [c_MAW-1:0] c_LAST_ADDR = c_MAW'(2 * N * N - 1);
    localparam logic [c_KW-1:0]  c_LAST_STEP = c_KW'(3 * N - 3);
    localparam logic [c_KW-1:0]  c_SNAP_STEP = c_KW'(3 * N - 2);
    localparam logic [c_BW-1:0]  c_LAST_BYTE = c_BW'(c_NBYTES - 1);
    localparam logic [SELW-1:0]  c_SEL_ZERO  = SELW'(N);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPUTE = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_MAW-1:0]    r_addr;
    logic [c_KW-1:0]     r_k;
    logic [c_BW-1:0]     r_b;
    logic [N*SELW-1:0]   r_sel;
    logic [N*N*AW-1:0]   r_snap;
    logic                r_done;
    logic                r_err;

    logic                w_start;    // last operand byte written this cycle
    logic                w_snap;     // compute finished, capture accumulators
    logic                w_xfer;     // output byte accepted by host
    logic [c_KW-1:0]     w_k_nxt;
    logic [N*SELW-1:0]   w_sel_nxt;
    logic [7:0]          w_bytes [c_NBYTES];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        o_mem_we    = 1'b0;
        o_clear     = 1'b0;
        o_pe_en     = 1'b0;
        o_out_valid = 1'b0;
        w_start     = 1'b0;
        w_snap      = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_load_en) begin
                    o_mem_we    = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (i_load_en) begin
                    o_mem_we = 1'b1;
                    if (r_addr == c_LAST_ADDR) begin
                        w_start     = 1'b1;
                        w_state_nxt = S_COMPUTE;
                    end
                end
            end
            S_COMPUTE: begin
                o_clear = (r_k == '0);
                o_pe_en = (r_k <= c_LAST_STEP);
                if (r_k == c_SNAP_STEP) begin
                    w_snap      = 1'b1;
                    w_state_nxt = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                o_out_valid = 1'b1;
                w_xfer      = i_out_ready;
                if (i_out_ready && (r_b == c_LAST_BYTE)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Skewed select generation. Selects are registered, so they are
    // computed from the step index of the following cycle.
    // ------------------------------------------------------------------
    assign w_k_nxt = w_start ? '0 : (r_k + 1'b1);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_sel
            assign w_sel_nxt[gi*SELW +: SELW] =
                ((int'(w_k_nxt) >= gi) && ((int'(w_k_nxt) - gi) < N))
                    ? SELW'(int'(w_k_nxt) - gi) : c_SEL_ZERO;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Counters, selects and status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_k    <= '0;
            r_b    <= '0;
            r_sel  <= {N{c_SEL_ZERO}};
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (o_mem_we) begin
                r_addr <= (r_addr == c_LAST_ADDR) ? '0 : (r_addr + 1'b1);
            end

            if (w_start) begin
                r_k   <= '0;
                r_sel <= w_sel_nxt;
            end else if (r_state == S_COMPUTE) begin
                if (w_snap) begin
                    r_k   <= '0;
                    r_sel <= {N{c_SEL_ZERO}};
                end else begin
                    // At the last step w_sel_nxt is already all-zero codes.
                    r_k   <= w_k_nxt;
                    r_sel <= w_sel_nxt;
                end
            end

            if (w_xfer) begin
                if (r_b == c_LAST_BYTE) begin
                    r_b    <= '0;
                    r_done <= 1'b1;
                end else begin
                    r_b <= r_b + 1'b1;
                end
            end

            if (i_load_en && ((r_state == S_COMPUTE) || (r_state == S_OUTPUT))) begin
                r_err <= 1'b1;
            end
        end
    end

    // Snapshot is free of reset: its contents only matter in OUTPUT,
    // which is always preceded by a capture.
    always_ff @(posedge clk) begin
        if (w_snap) begin
            r_snap <= i_c_flat;
        end
    end

    // ------------------------------------------------------------------
    // Byte stream order: PE row-major, MSB byte first within a PE
    // ------------------------------------------------------------------
    generate
        for (genvar gp = 0; gp < N * N; gp++) begin : g_pe
            for (genvar gq = 0; gq < c_BPP; gq++) begin : g_byte
                assign w_bytes[gp*c_BPP + gq] = r_snap[gp*AW + (c_BPP-1-gq)*8 +: 8];
            end
        end
    endgenerate

    assign o_out_byte = (r_state == S_OUTPUT) ? w_bytes[r_b] : 8'h00;
    assign o_mem_addr = r_addr;
    // Square array: row and column skews coincide.
    assign o_a_sel    = r_sel;
    assign o_b_sel    = r_sel;
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = r_done;
    assign o_load_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sa_ctrl_nxn.sv
`default_nettype none
// ============================================================================
// Module      : tb_sa_ctrl_nxn
// Description : Self-checking bench for sa_ctrl_nxn (N=2 and N=3 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sa_ctrl_nxn;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // N=2, AW=16 instance
    logic        ld2, rdy2;
    logic [63:0] cf2;
    logic [2:0]  addr2;
    logic        we2, clr2, pe2;
    logic [3:0]  as2, bs2;
    logic [7:0]  ob2;
    logic        ov2, busy2, done2, err2;

    // N=3, AW=16 instance
    logic         ld3, rdy3;
    logic [143:0] cf3;
    logic [4:0]   addr3;
    logic         we3, clr3, pe3;
    logic [5:0]   as3, bs3;
    logic [7:0]   ob3;
    logic         ov3, busy3, done3, err3;

    sa_ctrl_nxn #(.N(2), .AW(16)) u_dut2 (
        .clk(clk), .rst(rst), .i_load_en(ld2), .i_c_flat(cf2), .i_out_ready(rdy2),
        .o_mem_addr(addr2), .o_mem_we(we2), .o_clear(clr2), .o_pe_en(pe2),
        .o_a_sel(as2), .o_b_sel(bs2), .o_out_byte(ob2), .o_out_valid(ov2),
        .o_busy(busy2), .o_done(done2), .o_load_err(err2)
    );

    sa_ctrl_nxn #(.N(3), .AW(16)) u_dut3 (
        .clk(clk), .rst(rst), .i_load_en(ld3), .i_c_flat(cf3), .i_out_ready(rdy3),
        .o_mem_addr(addr3), .o_mem_we(we3), .o_clear(clr3), .o_pe_en(pe3),
        .o_a_sel(as3), .o_b_sel(bs3), .o_out_byte(ob3), .o_out_valid(ov3),
        .o_busy(busy3), .o_done(done3), .o_load_err(err3)
    );

    typedef struct {
        logic       pe;
        logic       clr;
        logic [3:0] sel;
    } cvec_t;

    cvec_t      ctab  [5];
    logic [7:0] otab  [8];
    logic [7:0] bptab [8];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Eight back-to-back operand bytes; ends in the first COMPUTE cycle.
    task automatic load2();
        for (int i = 0; i < 8; i++) begin
            ld2 = 1'b1;
            #1;
            chk("load_we", we2, 1);
            chk("load_addr", addr2, i);
            chk("load_clear", clr2, 0);
            step();
        end
        ld2 = 1'b0;
    endtask

    // Table-driven check of the compute phase; ends in the first OUTPUT cycle.
    task automatic compute2(input logic [63:0] c);
        cf2 = c;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("cmp_pe_en", pe2, ctab[j].pe);
            chk("cmp_clear", clr2, ctab[j].clr);
            chk("cmp_a_sel", as2, ctab[j].sel);
            chk("cmp_b_sel", bs2, ctab[j].sel);
            step();
        end
        cf2 = 64'hFFFF_EEEE_DDDD_CCCC;   // array reuse must not disturb the stream
    endtask

    task automatic out_full2();
        rdy2 = 1'b1;
        for (int b = 0; b < 8; b++) begin
            #1;
            chk("out_valid", ov2, 1);
            chk("out_byte", ob2, otab[b]);
            chk("out_done_low", done2, 0);
            step();
        end
        rdy2 = 1'b0;
        #1;
        chk("done_pulse", done2, 1);
        chk("done_valid_low", ov2, 0);
        chk("done_busy_low", busy2, 0);
        step();
        #1;
        chk("done_once", done2, 0);
    endtask

    task automatic drain2();
        int c = 0;
        rdy2 = 1'b1;
        while (!done2 && c < 40) begin
            step();
            c++;
        end
        chk("drain_done", done2, 1);
        rdy2 = 1'b0;
    endtask

    initial begin
        ctab[0] = '{1'b1, 1'b1, 4'h8};   // k0: slot0=0, slot1=2
        ctab[1] = '{1'b1, 1'b0, 4'h1};   // k1: slot0=1, slot1=0
        ctab[2] = '{1'b1, 1'b0, 4'h6};   // k2: slot0=2, slot1=1
        ctab[3] = '{1'b1, 1'b0, 4'hA};   // k3: slot0=2, slot1=2
        ctab[4] = '{1'b0, 1'b0, 4'hA};   // snapshot cycle
        otab  = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04};
        bptab = '{8'hA5, 8'hC3, 8'h12, 8'h34, 8'hBE, 8'hEF, 8'hDE, 8'hAD};

        rst = 1'b1;
        ld2 = 1'b0; rdy2 = 1'b0; cf2 = '0;
        ld3 = 1'b0; rdy3 = 1'b0; cf3 = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_addr", addr2, 0);
        chk("rst_we", we2, 0);
        chk("rst_clear", clr2, 0);
        chk("rst_pe_en", pe2, 0);
        chk("rst_valid", ov2, 0);
        chk("rst_done", done2, 0);
        chk("rst_err", err2, 0);
        chk("rst_byte", ob2, 0);
        chk("rst_busy", busy2, 0);
        chk("rst_a_sel", as2, 4'hA);
        chk("rst_b_sel", bs2, 4'hA);
        chk("rst_a_sel3", as3, 6'h3F);
        step();

        // Basic load, compute and unstalled output
        load2();
        compute2({16'h0004, 16'h0003, 16'h0002, 16'h0001});
        out_full2();

        // Output backpressure with ready pattern 1,0,0,1,0,0...
        begin
            int idx = 0;
            int cyc = 0;
            load2();
            compute2({16'hDEAD, 16'hBEEF, 16'h1234, 16'hA5C3});
            while (idx < 8 && cyc < 60) begin
                rdy2 = (cyc % 3 == 0);
                #1;
                chk("bp_valid", ov2, 1);
                chk("bp_byte", ob2, bptab[idx]);
                if (rdy2) idx++;
                cyc++;
                step();
            end
            rdy2 = 1'b0;
            chk("bp_transfers", idx, 8);
            #1;
            chk("bp_done", done2, 1);
            chk("bp_valid_low", ov2, 0);
            step();
        end

        // load_en during COMPUTE is ignored and sticky-flagged
        load2();
        ld2 = 1'b1;
        #1;
        chk("err_we", we2, 0);
        step();
        ld2 = 1'b0;
        #1;
        chk("err_set", err2, 1);
        chk("err_addr_hold", addr2, 0);
        drain2();
        chk("err_sticky_idle", err2, 1);
        chk("err_idle_busy", busy2, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("err_cleared", err2, 0);
        step();

        // Reset mid-OUTPUT after three bytes, then a fresh operation
        begin
            int c = 0;
            load2();
            while (!ov2 && c < 20) begin
                step();
                c++;
            end
            chk("mid_wait_valid", ov2, 1);
            rdy2 = 1'b1;
            step();
            step();
            step();
            rst  = 1'b1;
            rdy2 = 1'b0;
            step();
            #1;
            chk("mid_rst_valid", ov2, 0);
            chk("mid_rst_busy", busy2, 0);
            chk("mid_rst_done", done2, 0);
            rst = 1'b0;
            step();
            load2();
            compute2({16'h0004, 16'h0003, 16'h0002, 16'h0001});
            out_full2();
        end

        // N=3: 18-byte load with gaps, 7 compute steps, slot-2 skew
        for (int i = 0; i < 18; i++) begin
            ld3 = 1'b1;
            #1;
            chk("n3_we", we3, 1);
            chk("n3_addr", addr3, i);
            step();
            if (i < 17) begin
                ld3 = 1'b0;
                #1;
                chk("n3_gap_we", we3, 0);
                step();
            end
        end
        ld3 = 1'b0;
        begin
            int npe = 0;
            for (int c = 0; c < 12; c++) begin
                #1;
                if (c == 0) chk("n3_clear", clr3, 1);
                if (pe3) begin
                    chk("n3_a_sel2", as3[5:4], (npe >= 2 && npe <= 4) ? npe - 2 : 3);
                    chk("n3_b_sel2", bs3[5:4], (npe >= 2 && npe <= 4) ? npe - 2 : 3);
                    npe++;
                end
                step();
            end
            chk("n3_pe_cycles", npe, 7);
        end
        begin
            int c = 0;
            rdy3 = 1'b1;
            while (!done3 && c < 80) begin
                step();
                c++;
            end
            chk("n3_done", done3, 1);
            rdy3 = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sa_ctrl_nxn.md
Name: sa_ctrl_nxn

Overview:
- Parametrised control unit for an NxN output-stationary systolic array of MAC PEs.
- Issues write addresses for a 2·N·N-byte host load stream: N·N weights, then N·N inputs.
- Sequences skewed operand selects into the array edge and pulses clear at compute start.
- Snapshots the N·N accumulators, then serialises them to the host byte-wise with a valid/ready handshake.

Parameters:
- N, 2, array dimension (2..8).
- AW, 16, accumulator width; multiple of 8.
- SELW, $clog2(N+1), select width; code N means "feed zero".

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- load_en  in  1  host byte strobe; one operand byte per cycle.
- c_flat  in  N*N*AW  accumulators, PE(i,j) at bits [(i*N+j)*AW +: AW].
- out_ready  in  1  host accepts out_byte.
- mem_addr  out  $clog2(2*N*N)  operand buffer write address.
- mem_we  out  1  write strobe, equals load_en in LOAD/IDLE.
- clear  out  1  one-cycle accumulator clear.
- pe_en  out  1  array advance enable.
- a_sel  out  N*SELW  row i weight-column select, slot i.
- b_sel  out  N*SELW  column j input-row select, slot j.
- out_byte  out  8  result byte.
- out_valid  out  1  out_byte valid.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after last byte accepted.
- load_err  out  1  sticky; load_en seen outside IDLE/LOAD.

Behaviour:
- Reset values: state IDLE; all counters 0; mem_addr=0, mem_we=0, clear=0, pe_en=0, out_valid=0, done=0, load_err=0; out_byte=0; every a_sel/b_sel slot = N.
- States: IDLE, LOAD, COMPUTE, OUTPUT.
- IDLE:
  - load_en -> mem_we=1 at mem_addr=0; mem_addr increments; go LOAD.
- LOAD:
  - Each load_en writes at mem_addr, then increments mem_addr.
  - Write at address 2N²-1 -> mem_addr wraps to 0; next cycle enter COMPUTE with clear=1 for exactly that cycle; step counter k=0.
  - Gaps in load_en allowed; no timeout.
- COMPUTE:
  - pe_en=1 for k=0..3N-3 (3N-2 cycles).
  - a_sel slot i = k-i if 0≤k-i<N, else N.
  - b_sel slot j = k-j if 0≤k-j<N, else N.
  - Selects are registered: the value for step k is visible in the cycle pe_en is high for step k. Selects are N outside COMPUTE.
  - Cycle after step 3N-3: latch all of c_flat into the snapshot register, go OUTPUT.
  - The array may then be reused; snapshot is independent of c_flat.
- OUTPUT:
  - Byte index b = 0..N·N·(AW/8)-1.
  - Order: PE row-major (0,0),(0,1)…; within a PE, MSB byte first.
  - out_valid=1; out_byte is held stable until out_ready.
  - Transfer = out_valid & out_ready; advance one byte per transfer.
  - Transfer of last byte -> done=1 next cycle, out_valid=0, return to IDLE.
- Overlap and errors:
  - load_en in COMPUTE/OUTPUT is ignored (no write, mem_we=0) and sets load_err.
  - load_err is cleared only by rst.
- Arithmetic: accumulators are treated as raw bits; no saturation or sign handling here.
- Reset mid-operation: immediate return to reset values. Snapshot contents are don't-care; no further out_valid.
- Simultaneous done and new load_en: done is asserted in IDLE, so load_en that cycle is accepted and starts LOAD.

Test Plan:
- N=2, AW=16; load bytes 1..8 back-to-back -> mem_addr 0..7 with mem_we; clear pulses once. a_sel per step: k0 {0,2}; k1 {1,0}; k2 {2,1}; k3 {2,2}. b_sel identical. pe_en is high 4 cycles.
- N=2; drive c_flat = {0x0004,0x0003,0x0002,0x0001} (PE11..PE00) at snapshot, then change c_flat -> stream reads 00 01 00 02 00 03 00 04; done pulses once.
- N=3, AW=16; full 18-byte load with load_en gaps -> pe_en high 7 cycles; a_sel slot 2 equals 0,1,2 at k=2,3,4 and 3 elsewhere.
- Output backpressure: out_ready toggled 1,0,0,1… -> out_byte stable while stalled; no byte skipped or duplicated; exactly 2N² transfers.
- load_en during COMPUTE -> mem_we stays 0, load_err=1 and stays set through the next IDLE; rst clears it.
- rst asserted mid-OUTPUT after 3 bytes -> next cycle out_valid=0 and busy=0; a fresh load completes normally.
